// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FPGA<->host serial link (uart_receive and
// uart_transmit): default frame geometry and the receiver state encoding.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Defaults shared by both ends of the link.
  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // Receiver states.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial input.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous, active-high reset (both flops reset to 1)
//   i_async  asynchronous serial line, idle high
//   o_sync   i_async delayed by two i_clk cycles
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  // Both flops reset to the idle level so that leaving reset never looks
  // like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta   <= 1'b1;
      o_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make this a true two-stage shift;
      // blocking ones would collapse both flops into a single stage.
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// ---------------------------------------------------------------------------
// uart_receive
// Serial-to-parallel UART receiver: 1 start bit (0), DATA_BITS data bits LSB
// first, 1 stop bit (1). Each bit is sampled at its mid-point, counted from
// the synchronised start edge.
// Ports:
//   i_clk        system clock, all logic on posedge
//   i_rst        synchronous, active-high reset
//   i_rx         asynchronous serial input, idle high
//   o_data       last good word, held until the next good frame
//   o_valid      1-cycle pulse: o_data updated this cycle
//   o_frame_err  1-cycle pulse: stop bit sampled 0, word discarded
//   o_busy       high in every state except idle
// ---------------------------------------------------------------------------
module uart_receive
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Half-bit terminal count places every later sample at mid-bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_rx),
    .o_sync  (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;

      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= RX_START;
            o_busy <= 1'b1;
          end
        end

        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              // Line back high at mid start bit: a glitch, not a frame.
              state  <= RX_IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= RX_DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            // LSB arrives first: shift right, new bit enters at the MSB.
            shreg <= (shreg >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
            if (idx == IDX_LAST) begin
              state <= RX_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RX_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s) begin
              // Back to idle at stop mid-point so a start edge in the
              // second half of the stop bit is still caught.
              o_data  <= shreg;
              o_valid <= 1'b1;
              state   <= RX_IDLE;
              o_busy  <= 1'b0;
            end else begin
              o_frame_err <= 1'b1;
              state       <= RX_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RX_BREAK: begin
          // Wait out a held-low line so it reports only one frame error.
          cnt <= '0;
          if (rx_s) begin
            state  <= RX_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= RX_IDLE;
          cnt    <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
